// File: rtl/bcd_serial_adder_if.sv
// Handshake bus for the digit-serial BCD add/subtract unit.
// master drives operands and consumes results; slave is the adder.
interface bcd_serial_adder_if #(parameter int DIGITS = 4);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   s;
  logic                  cout;
  logic                  err;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, err
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, err
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder/subtractor, one digit per clock, LSD first.
// Subtraction uses nine's complement of B with cin acting as the +1.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_serial_adder_if.slave   io
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [W-1:0]   opa, opb, acc;
  logic           sub_r, carry, err_r;
  logic [IW-1:0]  idx;

  logic           in_ready, out_valid, cout, err;
  logic [W-1:0]   s;

  logic           in_err;
  logic [3:0]     b_dig, digit;
  logic [4:0]     t;
  logic           carry_nx;
  logic [W+3:0]   acc_sh;

  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (io.a[4*i +: 4] > 4'd9 || io.b[4*i +: 4] > 4'd9) in_err = 1'b1;
  end

  // Operands shift right each RUN cycle, so the live digit is always [3:0].
  always_comb begin
    b_dig    = sub_r ? (4'd9 - opb[3:0]) : opb[3:0];
    t        = {1'b0, opa[3:0]} + {1'b0, b_dig} + {4'd0, carry};
    digit    = t[3:0];
    carry_nx = 1'b0;
    if (t > 5'd9) begin
      digit    = t[3:0] + 4'd6;
      carry_nx = 1'b1;
    end
    acc_sh = {digit, acc};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      sub_r     <= 1'b0;
      carry     <= 1'b0;
      err_r     <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: if (io.in_valid && in_ready) begin
          opa      <= io.a;
          opb      <= io.b;
          sub_r    <= io.sub;
          carry    <= io.cin;
          err_r    <= in_err;
          idx      <= '0;
          acc      <= '0;
          in_ready <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          opa   <= opa >> 4;
          opb   <= opb >> 4;
          acc   <= acc_sh[W+3:4];
          carry <= carry_nx;
          idx   <= idx + 1'b1;
          if (idx == IW'(DIGITS - 1)) state <= DONE;
        end
        DONE: begin
          // First DONE cycle publishes the result; later cycles wait for the consumer.
          if (!out_valid) begin
            s         <= acc;
            cout      <= carry;
            err       <= err_r;
            out_valid <= 1'b1;
          end else if (io.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid;
  assign io.s         = s;
  assign io.cout      = cout;
  assign io.err       = err;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Vector table plus handshake/reset sequences for bcd_serial_adder (DIGITS=4).
module tb_bcd_serial_adder;
  localparam int DIGITS = 4;

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        cout, err;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        cout, err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t vecs[12];

  bcd_serial_adder_if #(.DIGITS(DIGITS)) bus();

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation; optionally hold off the consumer and pulse a stray in_valid mid-RUN.
  task automatic run_op(input vec_t v, input bit bp, input string tag);
    int   cyc;
    exp_t e;
    logic [15:0] s_hold;
    logic        c_hold;
    @(negedge clk);
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    chk({tag, " in_ready before accept"}, {31'd0, bus.in_ready}, 32'd1);
    bus.a = v.a; bus.b = v.b; bus.cin = v.cin; bus.sub = v.sub;
    bus.in_valid  = 1'b1;
    bus.out_ready = !bp;
    @(posedge clk);
    sb.push_back('{s: v.s, cout: v.cout, err: v.err});
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      if (cyc == 2) chk({tag, " in_ready busy"}, {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); cyc++;
      @(negedge clk);
      if (bp && cyc == 2) begin
        bus.a = 16'h1111; bus.b = 16'h1111; bus.sub = 1'b0; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    chk({tag, " latency"}, cyc, 32'd5);
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, " err"}, {31'd0, bus.err}, {31'd0, e.err});
    if (!e.err) begin
      chk({tag, " s"}, {16'd0, bus.s}, {16'd0, e.s});
      chk({tag, " cout"}, {31'd0, bus.cout}, {31'd0, e.cout});
    end
    if (bp) begin
      s_hold = bus.s; c_hold = bus.cout;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        chk({tag, " bp hold"}, {bus.out_valid, bus.in_ready, bus.cout, bus.s},
            {1'b1, 1'b0, c_hold, s_hold});
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, " handshake"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{16'h1234, 16'h8766, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{16'h0999, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
    vecs[2]  = '{16'h5000, 16'h1234, 1'b1, 1'b1, 16'h3766, 1'b1, 1'b0};
    vecs[3]  = '{16'h1234, 16'h5000, 1'b1, 1'b1, 16'h6234, 1'b0, 1'b0};
    vecs[4]  = '{16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[5]  = '{16'h4321, 16'h1234, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[6]  = '{16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0};
    vecs[9]  = '{16'h5000, 16'h1234, 1'b0, 1'b1, 16'h3765, 1'b1, 1'b0};
    vecs[10] = '{16'h0100, 16'h000B, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[11] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset state", {bus.in_ready, bus.out_valid, bus.cout, bus.err, bus.s},
        {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_op(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Backpressure with a stray in_valid during RUN; the stray must not start a second op.
    run_op(vecs[1], 1'b1, "bp");
    repeat (8) begin
      @(negedge clk);
      chk("no stray result", {31'd0, bus.out_valid}, 32'd0);
    end

    // Reset on the second RUN cycle aborts the operation.
    @(negedge clk);
    bus.a = 16'h4444; bus.b = 16'h4444; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid-run reset", {bus.in_ready, bus.out_valid, bus.cout, bus.err, bus.s},
        {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no result after abort", {31'd0, bus.out_valid}, 32'd0);
    end
    run_op('{16'h0005, 16'h0005, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0}, 1'b0, "post-reset");

    chk("scoreboard drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
